// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA pixel/line counters with registered sync, colour and line/frame markers
// Counters advance on the divided pixel tick; every output is registered exactly one tick behind its coordinate.
module vga_timing_gen #(
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter int HS_POL  = 0,
  parameter int VS_POL  = 0,
  parameter int COLOR_W = 1,
  parameter int CLK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [3*COLOR_W-1:0] pixval,
  output logic [9:0]           xpix,
  output logic [9:0]           ypix,
  output logic                 pix_tick,
  output logic                 hsync,
  output logic                 vsync,
  output logic [COLOR_W-1:0]   red,
  output logic [COLOR_W-1:0]   green,
  output logic [COLOR_W-1:0]   blue,
  output logic                 de,
  output logic                 line_start,
  output logic                 frame_start
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  // Phase boundaries are held one bit wider than the counters so H_VIS/V_VIS up to 1024 still compare correctly.
  localparam logic [10:0] H_VIS_C    = 11'(H_VIS);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VIS + H_FP);
  localparam logic [10:0] H_SYNC_END = 11'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [10:0] V_VIS_C    = 11'(V_VIS);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VIS + V_FP);
  localparam logic [10:0] V_SYNC_END = 11'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);

  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [9:0]         x_q, x_d;
  logic [9:0]         y_q, y_d;
  logic               tick;

  logic [10:0]        x_ext, y_ext;
  logic               h_vis, v_vis, h_sync, v_sync, visible;

  logic               hs_q, hs_d;
  logic               vs_q, vs_d;
  logic               de_q, de_d;
  logic               ls_q, ls_d;
  logic               fs_q, fs_d;
  logic [COLOR_W-1:0] r_q, r_d;
  logic [COLOR_W-1:0] g_q, g_d;
  logic [COLOR_W-1:0] b_q, b_d;

  assign tick = (div_q == DIV_LAST);

  always_comb begin
    div_d = tick ? '0 : div_q + DIV_W'(1);
    x_d   = x_q;
    y_d   = y_q;
    if (tick) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
    end
  end

  assign x_ext   = {1'b0, x_q};
  assign y_ext   = {1'b0, y_q};
  assign h_vis   = (x_ext < H_VIS_C);
  assign v_vis   = (y_ext < V_VIS_C);
  assign h_sync  = (x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END);
  assign v_sync  = (y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END);
  assign visible = h_vis && v_vis;

  always_comb begin
    hs_d = h_sync ? HS_ACT : ~HS_ACT;
    vs_d = v_sync ? VS_ACT : ~VS_ACT;
    de_d = visible;
    ls_d = (x_q == 10'd0) && v_vis;
    fs_d = (x_q == 10'd0) && (y_q == 10'd0);
    r_d  = '0;
    g_d  = '0;
    b_d  = '0;
    if (visible) begin
      r_d = pixval[3*COLOR_W-1:2*COLOR_W];
      g_d = pixval[2*COLOR_W-1:COLOR_W];
      b_d = pixval[COLOR_W-1:0];
    end
  end

  // Sync registers reset straight to the idle level, so an asynchronous reset never passes through the active level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hs_q <= ~HS_ACT;
      vs_q <= ~VS_ACT;
      de_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
    end else if (tick) begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      de_q <= de_d;
      ls_q <= ls_d;
      fs_q <= fs_d;
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
    end
  end

  assign xpix        = x_q;
  assign ypix        = y_q;
  assign pix_tick    = tick;
  assign hsync       = hs_q;
  assign vsync       = vs_q;
  assign de          = de_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign red         = r_q;
  assign green       = g_q;
  assign blue        = b_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks of vga_timing_gen over several parameter sets
// Outputs are sampled on the falling edge; k counts rising edges since the instance left reset.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Default timing, CLK_DIV=1
  logic       rst_def;
  logic [2:0] pix_def;
  logic [9:0] def_x, def_y;
  logic       def_tick, def_hs, def_vs, def_de, def_ls, def_fs;
  logic       def_r, def_g, def_b;

  // Default timing, CLK_DIV=4
  logic       rst_div;
  logic [2:0] pix_div;
  logic [9:0] div_x, div_y;
  logic       div_tick, div_hs, div_vs, div_de, div_ls, div_fs;
  logic       div_r, div_g, div_b;

  // Default timing, COLOR_W=4
  logic        rst_col;
  logic [11:0] pix_col;
  logic [9:0]  col_x, col_y;
  logic        col_tick, col_hs, col_vs, col_de, col_ls, col_fs;
  logic [3:0]  col_r, col_g, col_b;

  // Small frame 15x9, CLK_DIV=2
  logic       rst_sml;
  logic [2:0] pix_sml;
  logic [9:0] sml_x, sml_y;
  logic       sml_tick, sml_hs, sml_vs, sml_de, sml_ls, sml_fs;
  logic       sml_r, sml_g, sml_b;

  // Small frame 15x9, CLK_DIV=1, positive syncs
  logic       rst_pol;
  logic [2:0] pix_pol;
  logic [9:0] pol_x, pol_y;
  logic       pol_tick, pol_hs, pol_vs, pol_de, pol_ls, pol_fs;
  logic       pol_r, pol_g, pol_b;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst_def), .pixval(pix_def), .xpix(def_x), .ypix(def_y),
    .pix_tick(def_tick), .hsync(def_hs), .vsync(def_vs), .red(def_r), .green(def_g),
    .blue(def_b), .de(def_de), .line_start(def_ls), .frame_start(def_fs)
  );

  vga_timing_gen #(.CLK_DIV(4)) u_div (
    .clk(clk), .rst(rst_div), .pixval(pix_div), .xpix(div_x), .ypix(div_y),
    .pix_tick(div_tick), .hsync(div_hs), .vsync(div_vs), .red(div_r), .green(div_g),
    .blue(div_b), .de(div_de), .line_start(div_ls), .frame_start(div_fs)
  );

  vga_timing_gen #(.COLOR_W(4)) u_col (
    .clk(clk), .rst(rst_col), .pixval(pix_col), .xpix(col_x), .ypix(col_y),
    .pix_tick(col_tick), .hsync(col_hs), .vsync(col_vs), .red(col_r), .green(col_g),
    .blue(col_b), .de(col_de), .line_start(col_ls), .frame_start(col_fs)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .CLK_DIV(2)
  ) u_sml (
    .clk(clk), .rst(rst_sml), .pixval(pix_sml), .xpix(sml_x), .ypix(sml_y),
    .pix_tick(sml_tick), .hsync(sml_hs), .vsync(sml_vs), .red(sml_r), .green(sml_g),
    .blue(sml_b), .de(sml_de), .line_start(sml_ls), .frame_start(sml_fs)
  );

  vga_timing_gen #(
    .H_VIS(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_VIS(4), .V_FP(1), .V_SYNC(2), .V_BP(2), .HS_POL(1), .VS_POL(1)
  ) u_pol (
    .clk(clk), .rst(rst_pol), .pixval(pix_pol), .xpix(pol_x), .ypix(pol_y),
    .pix_tick(pol_tick), .hsync(pol_hs), .vsync(pol_vs), .red(pol_r), .green(pol_g),
    .blue(pol_b), .de(pol_de), .line_start(pol_ls), .frame_start(pol_fs)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({def_x, def_y} !== 20'd0) begin
      errors++; $display("FAIL reset_counters: got x=%0d y=%0d expected 0 0", def_x, def_y);
    end
    checks++;
    if ({def_hs, def_vs, def_de, def_ls, def_fs, def_r, def_g, def_b} !== 8'b1100_0000) begin
      errors++; $display("FAIL reset_outputs_neg: got hs,vs,de,ls,fs,rgb=%b expected 11000000",
                         {def_hs, def_vs, def_de, def_ls, def_fs, def_r, def_g, def_b});
    end
    checks++;
    if ({pol_hs, pol_vs} !== 2'b00) begin
      errors++; $display("FAIL reset_outputs_pos: got hs,vs=%b expected 00", {pol_hs, pol_vs});
    end
    checks++;
    if ({col_r, col_g, col_b} !== 12'h000) begin
      errors++; $display("FAIL reset_colour: got %h expected 000", {col_r, col_g, col_b});
    end
    checks++;
    if (def_tick !== 1'b1) begin
      errors++; $display("FAIL reset_tick_div1: got %b expected 1", def_tick);
    end
  endtask

  task automatic test_default_line();
    int hs_low0 = 0, hs_low1 = 0, hs_first = -1, de_cnt = 0, red_bad = 0, fs_cnt = 0;
    int ls_cnt = 0, ls_first = -1, ls_second = -1;
    logic ls_prev = 1'b0;
    rst_def = 1'b0;
    for (int k = 1; k <= 1600; k++) begin
      @(negedge clk);
      if (!def_hs) begin
        if (k <= 800) hs_low0++; else hs_low1++;
        if (hs_first < 0) hs_first = k;
      end
      if (k <= 800 && def_de) de_cnt++;
      if (def_r !== def_de) red_bad++;
      if (def_fs) fs_cnt++;
      if (def_ls && !ls_prev) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = k; else ls_second = k;
      end
      ls_prev = def_ls;
      if (k == 799) begin
        checks++;
        if (def_x !== 10'd799 || def_y !== 10'd0) begin
          errors++; $display("FAIL def_last_pixel: got x=%0d y=%0d expected 799 0", def_x, def_y);
        end
      end
      if (k == 800) begin
        checks++;
        if (def_x !== 10'd0 || def_y !== 10'd1) begin
          errors++; $display("FAIL def_x_wrap: got x=%0d y=%0d expected 0 1", def_x, def_y);
        end
      end
    end
    checks++;
    if (hs_first !== 657) begin
      errors++; $display("FAIL def_hsync_start: got %0d expected 657", hs_first);
    end
    checks++;
    if (hs_low0 !== 96 || hs_low1 !== 96) begin
      errors++; $display("FAIL def_hsync_width: got %0d/%0d expected 96/96", hs_low0, hs_low1);
    end
    checks++;
    if (de_cnt !== 640) begin
      errors++; $display("FAIL def_de_width: got %0d expected 640", de_cnt);
    end
    checks++;
    if (red_bad !== 0) begin
      errors++; $display("FAIL def_colour_gate: got %0d bad clks expected 0", red_bad);
    end
    checks++;
    if (ls_cnt !== 2 || ls_first !== 1 || ls_second !== 801) begin
      errors++; $display("FAIL def_line_period: got n=%0d at %0d,%0d expected 2 at 1,801",
                         ls_cnt, ls_first, ls_second);
    end
    checks++;
    if (fs_cnt !== 1) begin
      errors++; $display("FAIL def_frame_start: got %0d clks expected 1", fs_cnt);
    end
  endtask

  task automatic test_clk_div();
    int tick_cnt = 0, tick_first = -1, fs_cnt = 0, fs_first = -1, ls_first = -1, ls_second = -1;
    int max_x = 0;
    logic ls_prev = 1'b0;
    rst_div = 1'b0;
    for (int k = 1; k <= 3300; k++) begin
      @(negedge clk);
      if (k <= 40 && div_tick) begin
        tick_cnt++;
        if (tick_first < 0) tick_first = k;
      end
      if (div_fs) begin
        fs_cnt++;
        if (fs_first < 0) fs_first = k;
      end
      if (div_ls && !ls_prev) begin
        if (ls_first < 0) ls_first = k; else if (ls_second < 0) ls_second = k;
      end
      ls_prev = div_ls;
      if (int'(div_x) > max_x) max_x = int'(div_x);
      if (k == 3200) begin
        checks++;
        if (div_x !== 10'd0 || div_y !== 10'd1) begin
          errors++; $display("FAIL div_x_wrap: got x=%0d y=%0d expected 0 1", div_x, div_y);
        end
      end
    end
    checks++;
    if (tick_cnt !== 10 || tick_first !== 3) begin
      errors++; $display("FAIL div_tick: got n=%0d first=%0d expected 10 first=3", tick_cnt, tick_first);
    end
    checks++;
    if (fs_cnt !== 4 || fs_first !== 4) begin
      errors++; $display("FAIL div_fs_width: got n=%0d first=%0d expected 4 first=4", fs_cnt, fs_first);
    end
    checks++;
    if (ls_first !== 4 || ls_second !== 3204) begin
      errors++; $display("FAIL div_line_period: got %0d,%0d expected 4,3204", ls_first, ls_second);
    end
    checks++;
    if (max_x !== 799) begin
      errors++; $display("FAIL div_max_x: got %0d expected 799", max_x);
    end
  endtask

  task automatic test_colour();
    logic found = 1'b0;
    pix_col = 12'h000;
    rst_col = 1'b0;
    for (int k = 0; k < 9000 && !found; k++) begin
      @(negedge clk);
      if (col_x == 10'd10 && col_y == 10'd10) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL col_reach_10_10: got timeout expected coordinate (10,10)");
    end else begin
      pix_col = 12'hA5C;
      @(negedge clk);
      pix_col = 12'h000;
      checks++;
      if ({col_r, col_g, col_b, col_de} !== 13'b1010_0101_1100_1) begin
        errors++; $display("FAIL col_visible: got rgb=%h de=%b expected A5C de=1",
                           {col_r, col_g, col_b}, col_de);
      end
      @(negedge clk);
      checks++;
      if ({col_r, col_g, col_b} !== 12'h000) begin
        errors++; $display("FAIL col_latency: got %h expected 000", {col_r, col_g, col_b});
      end
      found = 1'b0;
      for (int k = 0; k < 1000 && !found; k++) begin
        if (col_x == 10'd700 && col_y == 10'd10) found = 1'b1;
        else @(negedge clk);
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL col_reach_700_10: got timeout expected coordinate (700,10)");
      end else begin
        pix_col = 12'hA5C;
        @(negedge clk);
        pix_col = 12'h000;
        checks++;
        if ({col_r, col_g, col_b, col_de} !== 13'd0) begin
          errors++; $display("FAIL col_blanked: got rgb=%h de=%b expected 000 de=0",
                             {col_r, col_g, col_b}, col_de);
        end
      end
    end
  endtask

  task automatic test_small_frame();
    int vs_cnt = 0, vs_first = -1, de_cnt = 0, r_cnt = 0, g_cnt = 0, ls_cnt = 0, tick_cnt = 0;
    int fs_cnt = 0, fs_first = -1, fs_second = -1;
    logic fs_prev = 1'b0;
    pix_sml = 3'b101;
    rst_sml = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      @(negedge clk);
      if (k <= 270) begin
        if (!sml_vs) begin
          vs_cnt++;
          if (vs_first < 0) vs_first = k;
        end
        if (sml_de) de_cnt++;
        if (sml_r) r_cnt++;
        if (sml_ls) ls_cnt++;
        if (sml_tick) tick_cnt++;
        if (sml_fs) fs_cnt++;
      end
      if (sml_g) g_cnt++;
      if (sml_fs && !fs_prev) begin
        if (fs_first < 0) fs_first = k; else if (fs_second < 0) fs_second = k;
      end
      fs_prev = sml_fs;
      if (k == 268) begin
        checks++;
        if (sml_x !== 10'd14 || sml_y !== 10'd8) begin
          errors++; $display("FAIL sml_last_coord: got x=%0d y=%0d expected 14 8", sml_x, sml_y);
        end
      end
      if (k == 270) begin
        checks++;
        if (sml_x !== 10'd0 || sml_y !== 10'd0) begin
          errors++; $display("FAIL sml_y_wrap: got x=%0d y=%0d expected 0 0", sml_x, sml_y);
        end
      end
    end
    checks++;
    if (vs_cnt !== 60 || vs_first !== 152) begin
      errors++; $display("FAIL sml_vsync: got n=%0d first=%0d expected 60 first=152", vs_cnt, vs_first);
    end
    checks++;
    if (de_cnt !== 64 || r_cnt !== 64 || g_cnt !== 0) begin
      errors++; $display("FAIL sml_visible: got de=%0d r=%0d g=%0d expected 64 64 0", de_cnt, r_cnt, g_cnt);
    end
    checks++;
    if (ls_cnt !== 8) begin
      errors++; $display("FAIL sml_line_start: got %0d clks expected 8", ls_cnt);
    end
    checks++;
    if (tick_cnt !== 135) begin
      errors++; $display("FAIL sml_ticks: got %0d expected 135", tick_cnt);
    end
    checks++;
    if (fs_cnt !== 2 || fs_first !== 2 || fs_second !== 272) begin
      errors++; $display("FAIL sml_frame_period: got n=%0d at %0d,%0d expected 2 at 2,272",
                         fs_cnt, fs_first, fs_second);
    end
  endtask

  task automatic test_mid_sync_reset();
    logic found = 1'b0;
    int fs_rise = 0, fs_first = -1;
    logic fs_prev = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge clk);
      if (sml_x == 10'd12 && sml_y == 10'd5) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rst_reach_sync: got timeout expected coordinate (12,5)");
    end else begin
      checks++;
      if ({sml_hs, sml_vs} !== 2'b00) begin
        errors++; $display("FAIL rst_pre_sync: got hs,vs=%b expected 00", {sml_hs, sml_vs});
      end
      #2 rst_sml = 1'b1;
      #1;
      checks++;
      if ({sml_hs, sml_vs, sml_de} !== 3'b110 || sml_x !== 10'd0 || sml_y !== 10'd0) begin
        errors++; $display("FAIL rst_async: got hs,vs,de=%b x=%0d y=%0d expected 110 0 0",
                           {sml_hs, sml_vs, sml_de}, sml_x, sml_y);
      end
      repeat (2) @(negedge clk);
      rst_sml = 1'b0;
      for (int k = 1; k <= 250; k++) begin
        @(negedge clk);
        if (k == 1 || k == 2) begin
          checks++;
          if (sml_x !== 10'(k - 1)) begin
            errors++; $display("FAIL rst_restart_x%0d: got %0d expected %0d", k, sml_x, k - 1);
          end
        end
        if (sml_fs && !fs_prev) begin
          fs_rise++;
          if (fs_first < 0) fs_first = k;
        end
        fs_prev = sml_fs;
      end
      checks++;
      if (fs_rise !== 1 || fs_first !== 2) begin
        errors++; $display("FAIL rst_frame_start: got n=%0d first=%0d expected 1 first=2", fs_rise, fs_first);
      end
    end
  endtask

  task automatic test_polarity();
    int hs_cnt = 0, hs_first = -1, vs_cnt = 0;
    rst_pol = 1'b0;
    for (int k = 1; k <= 135; k++) begin
      @(negedge clk);
      if (pol_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = k;
      end
      if (pol_vs) vs_cnt++;
    end
    checks++;
    if (hs_cnt !== 27 || hs_first !== 11) begin
      errors++; $display("FAIL pol_hsync: got n=%0d first=%0d expected 27 first=11", hs_cnt, hs_first);
    end
    checks++;
    if (vs_cnt !== 30) begin
      errors++; $display("FAIL pol_vsync: got %0d expected 30", vs_cnt);
    end
  endtask

  initial begin
    rst_def = 1'b1; rst_div = 1'b1; rst_col = 1'b1; rst_sml = 1'b1; rst_pol = 1'b1;
    pix_def = 3'b111; pix_div = 3'b111; pix_col = 12'h000; pix_sml = 3'b101; pix_pol = 3'b111;
    test_reset();
    test_default_line();
    test_clk_div();
    test_colour();
    test_small_frame();
    test_mid_sync_reset();
    test_polarity();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
